// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold,
    StDiscard
  } fetch_state_t;

  // Instruction addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [INST_W-1:0] word_align(input logic [INST_W-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter: async-reset register with load enable.
module pc_register
  import mips_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [INST_W-1:0] d,
  output logic [INST_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the req/ack imem port and feeds IF/ID.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              redirect,
  input  logic [INST_W-1:0] redirect_target,
  output logic              imem_req,
  output logic [INST_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] if_pc_plus4,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid
);

  fetch_state_t      state_q, state_d;
  logic [INST_W-1:0] pc_q, pc_d, pc_plus4, target;
  logic              pc_load;
  logic [INST_W-1:0] hold_q, hold_d;
  logic [INST_W-1:0] disc_addr_q, disc_addr_d;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk (clk),
    .rst (rst),
    .load(pc_load),
    .d   (pc_d),
    .q   (pc_q)
  );

  assign pc_plus4    = pc_q + 32'd4;
  assign target      = word_align(redirect_target);
  assign if_pc_plus4 = pc_plus4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      disc_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      disc_addr_q <= disc_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_load     = 1'b0;
    pc_d        = pc_plus4;
    hold_d      = hold_q;
    disc_addr_d = disc_addr_q;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    if_valid    = 1'b0;
    if_inst     = NOP_INST;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (redirect) begin
          pc_load = 1'b1;
          pc_d    = target;
        end
      end
      StFetch: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_load = 1'b1;
          pc_d    = target;
          // An unacked request must still complete at its old address; park it.
          if (!imem_ack) begin
            state_d     = StDiscard;
            disc_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          if_valid = 1'b1;
          if_inst  = imem_rdata;
          if (pc_write) begin
            pc_load = 1'b1;
          end else begin
            hold_d  = imem_rdata;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          pc_load = 1'b1;
          pc_d    = target;
          state_d = StFetch;
        end else begin
          if_valid = 1'b1;
          if_inst  = hold_q;
          if (pc_write) begin
            pc_load = 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDiscard: begin
        imem_req  = 1'b1;
        imem_addr = disc_addr_q;
        if (redirect) begin
          pc_load = 1'b1;
          pc_d    = target;
        end
        if (imem_ack) begin
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rst) begin
      imem_req = 1'b0;
    end
  end

endmodule
